// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit counters, read-before-write lookup.
// Optional statistics counters are enabled by defining BP_STATS_EN.
module branch_predictor #(
  parameter int BTB_IDX_BITS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] pc,
  output logic [15:0] pred_pc,
  output logic        pred_taken,
  input  logic        upd_valid,
  input  logic [15:0] upd_pc,
  input  logic [15:0] upd_target,
  input  logic        upd_taken,
  input  logic        upd_cond,
  input  logic [2:0]  flush_code,
  output logic [15:0] lookup_cnt,
  output logic [15:0] mispred_cnt
);
  localparam int N  = 1 << BTB_IDX_BITS;
  localparam int TW = 16 - BTB_IDX_BITS;
  logic [N-1:0]            valid_q, unc_q;
  logic [TW-1:0]           tag_q [N];
  logic [15:0]             tgt_q [N];
  logic [1:0]              ctr_q [N];
  logic [BTB_IDX_BITS-1:0] ridx, widx;
  logic                    hit, uhit, we;
  logic [1:0]              ctr_d, uctr;
  assign ridx       = pc[BTB_IDX_BITS-1:0];
  assign widx       = upd_pc[BTB_IDX_BITS-1:0];
  assign hit        = valid_q[ridx] && tag_q[ridx] == pc[15:BTB_IDX_BITS];
  assign pred_taken = hit && (unc_q[ridx] || ctr_q[ridx][1]);
  assign pred_pc    = pred_taken ? tgt_q[ridx] : pc + 16'd1;
  assign uhit       = valid_q[widx] && tag_q[widx] == upd_pc[15:BTB_IDX_BITS];
  assign uctr       = ctr_q[widx];
  assign we         = upd_valid && (uhit || upd_taken);
  // jumps pin the counter at strong-taken; fresh conditional entries start weak-taken
  always_comb begin
    ctr_d = !upd_cond ? 2'd3 :
            !uhit     ? 2'd2 :
            upd_taken ? (uctr == 2'd3 ? 2'd3 : uctr + 2'd1) :
                        (uctr == 2'd0 ? 2'd0 : uctr - 2'd1);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      unc_q   <= '0;
      for (int i = 0; i < N; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        ctr_q[i] <= 2'd1;
      end
    end else if (we) begin
      valid_q[widx] <= 1'b1;
      unc_q[widx]   <= !upd_cond;
      tag_q[widx]   <= upd_pc[15:BTB_IDX_BITS];
      tgt_q[widx]   <= upd_target;
      ctr_q[widx]   <= ctr_d;
    end
  end
`ifdef BP_STATS_EN
  logic [15:0] lcnt_q, mcnt_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      lcnt_q <= '0;
      mcnt_q <= '0;
    end else begin
      if (upd_valid && lcnt_q != 16'hFFFF) lcnt_q <= lcnt_q + 16'd1;
      if (flush_code != 3'd0 && mcnt_q != 16'hFFFF) mcnt_q <= mcnt_q + 16'd1;
    end
  end
  assign lookup_cnt  = lcnt_q;
  assign mispred_cnt = mcnt_q;
`else
  logic unused_flush;
  assign unused_flush = ^flush_code;
  assign lookup_cnt   = '0;
  assign mispred_cnt  = '0;
`endif
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: scoreboard bench against a behavioural BTB model (BP_STATS_EN aware).
module tb_branch_predictor;
  logic        clk = 0, reset = 1, upd_valid = 0, upd_taken = 0, upd_cond = 0, pred_taken;
  logic [15:0] pc = 0, upd_pc = 0, upd_target = 0, pred_pc, lookup_cnt, mispred_cnt;
  logic [2:0]  flush_code = 0;
  int n_vec = 0, n_err = 0;
  always #5 clk = ~clk;
  branch_predictor #(.BTB_IDX_BITS(4)) dut (
    .clk(clk), .reset(reset), .pc(pc), .pred_pc(pred_pc), .pred_taken(pred_taken),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken),
    .upd_cond(upd_cond), .flush_code(flush_code), .lookup_cnt(lookup_cnt), .mispred_cnt(mispred_cnt)
  );
  typedef struct packed {logic [15:0] npc; logic tk; logic [15:0] lc, mc;} exp_t;
  exp_t sb[$];
  logic        m_v [16], m_u [16];
  logic [11:0] m_tag [16];
  logic [15:0] m_tgt [16];
  int          m_ctr [16];
  int          m_lc, m_mc;
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_v[i] = 0; m_u[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
    end
    m_lc = 0; m_mc = 0;
  endtask
  task automatic cyc(input logic r, input logic [15:0] p, input logic uv, input logic [15:0] up,
                     input logic [15:0] ut, input logic tk, input logic cnd, input logic [2:0] fc);
    int i, j;
    logic t;
    exp_t e;
    @(negedge clk);
    reset = r; pc = p; upd_valid = uv; upd_pc = up; upd_target = ut;
    upd_taken = tk; upd_cond = cnd; flush_code = fc;
    i = int'(p[3:0]);
    t = m_v[i] && m_tag[i] == p[15:4] && (m_u[i] || m_ctr[i] >= 2);
`ifdef BP_STATS_EN
    sb.push_back('{t ? m_tgt[i] : p + 16'd1, t, 16'(m_lc), 16'(m_mc)});
`else
    sb.push_back('{t ? m_tgt[i] : p + 16'd1, t, 16'd0, 16'd0});
`endif
    #1;
    e = sb.pop_front();
    check("pred_pc", pred_pc, e.npc);
    check("pred_taken", {15'd0, pred_taken}, {15'd0, e.tk});
    check("lookup_cnt", lookup_cnt, e.lc);
    check("mispred_cnt", mispred_cnt, e.mc);
    @(posedge clk);
    if (r) model_reset();
    else begin
      if (uv) begin
        j = int'(up[3:0]);
        if (m_v[j] && m_tag[j] == up[15:4]) begin
          m_tgt[j] = ut; m_u[j] = !cnd;
          if (!cnd) m_ctr[j] = 3;
          else if (tk) m_ctr[j] = (m_ctr[j] < 3) ? m_ctr[j] + 1 : 3;
          else m_ctr[j] = (m_ctr[j] > 0) ? m_ctr[j] - 1 : 0;
        end else if (tk) begin
          m_v[j] = 1; m_tag[j] = up[15:4]; m_tgt[j] = ut; m_u[j] = !cnd; m_ctr[j] = cnd ? 2 : 3;
        end
        if (m_lc < 65535) m_lc++;
      end
      if (fc != 0 && m_mc < 65535) m_mc++;
    end
  endtask
  task automatic look(input logic [15:0] p);
    cyc(0, p, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic upd(input logic [15:0] p, input logic [15:0] up, input logic [15:0] ut,
                     input logic tk, input logic cnd);
    cyc(0, p, 1, up, ut, tk, cnd, 0);
  endtask
  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    cyc(1, 16'h0005, 0, 0, 0, 0, 0, 0);
    look(16'h0005);
    upd(16'h0005, 16'h0005, 16'h0020, 1, 1);
    look(16'h0005);
    repeat (2) upd(16'h0005, 16'h0005, 16'h0020, 0, 1);
    look(16'h0005);
    repeat (4) upd(16'h0005, 16'h0005, 16'h0020, 1, 1);
    look(16'h0005);
    look(16'h0015);
    upd(16'h0015, 16'h0015, 16'h0040, 1, 1);
    look(16'h0005);
    look(16'h0015);
    upd(16'h0007, 16'h0007, 16'h0030, 0, 1);
    look(16'h0007);
    cyc(1, 16'h0005, 1, 16'h0005, 16'h0020, 1, 1, 0);
    look(16'h0005);
    look(16'h0015);
    look(16'hFFFF);
    upd(16'h0003, 16'h0003, 16'h0100, 1, 0);
    repeat (3) look(16'h0003);
    for (int k = 0; k < 5; k++) cyc(0, 16'h0003, 1, 16'h0009, 16'h0200, 1, 1, (k < 3) ? 3'd2 : 3'd0);
    look(16'h0009);
    cyc(1, 16'h0000, 0, 0, 0, 0, 0, 0);
    look(16'h0009);
    for (int k = 0; k < 400; k++)
      cyc(($urandom_range(0, 99) == 0), {12'($urandom_range(0, 2)), 4'($urandom)}, 1'($urandom),
          {12'($urandom_range(0, 2)), 4'($urandom)}, 16'($urandom), 1'($urandom), 1'($urandom),
          3'($urandom_range(0, 3)));
    look(16'h0000);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter BTB_IDX_BITS, default 4, meaning BTB index width (2^BTB_IDX_BITS entries, direct-mapped); legal range 2..8.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port pc, input, 16, current fetch PC.
REQ-005 SHALL have port pred_pc, output, 16, predicted next fetch PC.
REQ-006 SHALL have port pred_taken, output, 1, high when pred_pc comes from the BTB.
REQ-007 SHALL have port upd_valid, input, 1, a control instruction resolved in ID this cycle.
REQ-008 SHALL have port upd_pc, input, 16, PC of the resolved instruction.
REQ-009 SHALL have port upd_target, input, 16, resolved target (branch, jump or register target).
REQ-010 SHALL have port upd_taken, input, 1, resolved direction (1 for all jumps).
REQ-011 SHALL have port upd_cond, input, 1, 1 = conditional branch, 0 = unconditional jump/JPR/JRL.
REQ-012 SHALL have port flush_code, input, 3, mispredict code from the ID-stage detector (0 = correct prediction).
REQ-013 SHALL have port lookup_cnt, output, 16, resolved-control-instruction count.
REQ-014 SHALL have port mispred_cnt, output, 16, mispredict count.

Function
REQ-015 Each BTB entry SHALL hold valid, tag = pc[15:BTB_IDX_BITS], 16-bit target, 2-bit counter and uncond bit.
REQ-016 Lookup SHALL be combinational: index = pc[BTB_IDX_BITS-1:0]; hit = valid && tag match.
REQ-017 pred_taken SHALL be hit && (uncond || counter[1]).
REQ-018 pred_pc SHALL be the entry target when pred_taken, else pc+1 modulo 2^16 (0xFFFF -> 0x0000).
REQ-019 On a clk edge with upd_valid and no reset, the entry at upd_pc's index SHALL update; change visible one cycle later.
REQ-020 Update on hit: target <= upd_target; uncond <= !upd_cond; counter saturating +1 if upd_taken, -1 if not (0..3, no wrap); counter <= 3 if !upd_cond.
REQ-021 Update on miss with upd_taken=1: allocate (overwrite any aliased entry): valid=1, new tag, target, uncond=!upd_cond, counter = upd_cond ? 2 : 3.
REQ-022 Update on miss with upd_taken=0: no BTB write.
REQ-023 Lookup and update in the same cycle, same index: lookup SHALL see pre-update state (read-before-write).
REQ-024 Counter states: 0 strong-NT, 1 weak-NT, 2 weak-T, 3 strong-T; only REQ-020/021 transitions permitted.
REQ-025 Entries at other indices SHALL be unchanged by an update.

Reset
REQ-026 reset high at a clk edge SHALL clear all valid bits, set counters to 1, targets/tags/uncond to 0, and both statistic counters to 0; reset SHALL override a concurrent update.
REQ-027 After reset every lookup SHALL miss: pred_taken=0, pred_pc=pc+1.
REQ-028 Reset asserted mid-sequence SHALL discard all learned state within that one edge.

Configuration
REQ-029 Macro BP_STATS_EN defined: lookup_cnt SHALL increment on each clk edge with upd_valid; mispred_cnt SHALL increment on each edge with flush_code != 0; both saturate at 0xFFFF.
REQ-030 BP_STATS_EN undefined: lookup_cnt and mispred_cnt ports SHALL remain and be driven constant 0; no counter registers synthesized.

Verification (BTB_IDX_BITS=4)
REQ-031 Reset, pc=0x0005 -> pred_pc=0x0006, pred_taken=0.
REQ-032 Reset; one update upd_pc=0x0005, upd_target=0x0020, upd_cond=1, upd_taken=1; next cycle pc=0x0005 -> pred_pc=0x0020, pred_taken=1; same cycle as update -> pred_pc=0x0006.
REQ-033 After REQ-032, two not-taken updates on 0x0005 (counter 2->1->0) -> pred_pc=0x0006; four taken updates -> counter saturates at 3, pred_pc=0x0020.
REQ-034 Entry at 0x0005 present, pc=0x0015 (same index, different tag) -> pred_pc=0x0016; taken update at 0x0015 target 0x0040 evicts, then pc=0x0005 -> 0x0006.
REQ-035 Reset, pc=0xFFFF -> pred_pc=0x0000; uncond update upd_pc=0x0003 target 0x0100 upd_cond=0 -> pc=0x0003 gives 0x0100 even after 3 not-taken conditional updates are never applied.
REQ-036 With BP_STATS_EN: 5 edges upd_valid=1, 3 of them flush_code=3'd2 -> lookup_cnt=5, mispred_cnt=3; reset -> both 0; without macro both stay 0.
